// File: rtl/delivery_pkg.sv
// delivery_pkg: shared definitions for the delivery-game map path.
// Holds the scroller state encoding, the row LFSR polynomial and default
// seed, and the lane-index width helper used to size player_lane.
package delivery_pkg;

    // Scroller control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CRASH = 2'd3
    } state_t;

    // x^8 + x^6 + x^5 + x^4 + 1, written as the register bits that feed the
    // XOR when the register shifts toward the MSB (bits 7, 5, 4, 3).
    localparam logic [7:0] LFSR_TAPS         = 8'hB8;
    localparam logic [7:0] LFSR_SEED_DEFAULT = 8'hA5;

    // Bits needed to index v lanes (v >= 2).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/row_lfsr.sv
// row_lfsr: 8-bit Fibonacci LFSR that feeds obstacle-row generation.
// Latency: free-running, one step per clock once out of reset.
// Backpressure: none; it never stalls.
// Ports: clock, reset (sync, active-low, loads SEED), lfsr (current value).
module row_lfsr
    import delivery_pkg::*;
#(
    // Must be nonzero: the all-zero state is a lock-up state for this LFSR.
    parameter logic [7:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] lfsr
);

    logic feedback;

    assign feedback = ^(lfsr & LFSR_TAPS);

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[6:0], feedback};
        end
    end

endmodule

// File: rtl/map_scroller.sv
// map_scroller: scrolls the obstacle map down one row per move_map tick,
// inserts generated rows at the top, tests the player lane against the
// bottom row and counts survived obstacle rows as the score.
// Latency: tick sampled in RUN -> SHIFT next cycle -> map/score written at
//          the end of SHIFT -> hit test on the new bottom row in the next RUN.
// Backpressure: none upstream; a tick arriving during SHIFT is dropped, or
//          held in a one-deep pending flag when MAP_SCROLLER_PENDING_TICK_EN
//          is defined.
//
// Ports:
//   clock        system clock (game tick domain)
//   reset        synchronous, active-low
//   run          game active level from the control FSM
//   move_map     one-cycle scroll tick from the map timing block
//   player_lane  current player lane (clamped to LANES-1 for the hit test)
//   map_rows     flattened map, row r at [r*LANES +: LANES], 1 = obstacle
//   score        obstacle rows survived, saturating
//   crashed      high while in CRASH
//   collision    one-cycle pulse on the first CRASH cycle
//   busy         high during the SHIFT cycle
module map_scroller
    import delivery_pkg::*;
#(
    parameter int         LANES     = 4,
    parameter int         ROWS      = 8,
    parameter int         SCORE_W   = 10,
    parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     move_map,
    input  logic [clog2(LANES)-1:0]  player_lane,
    output logic [ROWS*LANES-1:0]    map_rows,
    output logic [SCORE_W-1:0]       score,
    output logic                     crashed,
    output logic                     collision,
    output logic                     busy
);

    state_t             state;
    state_t             state_nxt;

    logic [7:0]         lfsr;
    logic [LANES-1:0]   bottom_row;
    logic [LANES-1:0]   rand_row;
    logic [LANES-1:0]   ins_row;
    int                 lane_idx;
    int                 clr_lane;
    logic               hit;
    logic               tick;
    logic               new_game;
    logic               do_shift;
    logic               enter_crash;
    // Set after a random row has been inserted: the next insert is blank so a
    // free path always exists through every other row.
    logic               zero_turn;
    // Only part of the LFSR is consumed for a given LANES.
    logic               unused_lfsr_bits;

    row_lfsr #(
        .SEED  (LFSR_SEED)
    ) u_row_lfsr (
        .clock (clock),
        .reset (reset),
        .lfsr  (lfsr)
    );

    assign unused_lfsr_bits = ^lfsr;

    // ------------------------------------------------------------------
    // Hit test: bottom-row bit under the (clamped) player lane.
    // ------------------------------------------------------------------
    assign bottom_row = map_rows[(ROWS-1)*LANES +: LANES];

    always_comb begin
        lane_idx = int'(player_lane);
        if (lane_idx > LANES - 1) begin
            lane_idx = LANES - 1;
        end
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (i == lane_idx) begin
                hit = bottom_row[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // New top row: LFSR low bits, with one lane reopened if the row would
    // block every lane. Every second insert is forced blank.
    // ------------------------------------------------------------------
    assign clr_lane = int'(lfsr[7:5]) % LANES;

    always_comb begin
        rand_row = lfsr[LANES-1:0];
        if (&rand_row) begin
            for (int i = 0; i < LANES; i++) begin
                if (i == clr_lane) begin
                    rand_row[i] = 1'b0;
                end
            end
        end
    end

    assign ins_row = zero_turn ? '0 : rand_row;

    // ------------------------------------------------------------------
    // Tick source: raw move_map, plus the held tick when pending is built in.
    // ------------------------------------------------------------------
`ifdef MAP_SCROLLER_PENDING_TICK_EN
    logic pending;
    logic pending_nxt;

    assign tick = move_map | pending;

    always_comb begin
        pending_nxt = pending;
        case (state)
            // RUN always either consumes the held tick or leaves for a state
            // where it must not survive (IDLE, CRASH).
            ST_RUN:   pending_nxt = 1'b0;
            // Capture a tick that lands on the shift cycle; a second one
            // while already set is simply absorbed.
            ST_SHIFT: pending_nxt = run & (pending | move_map);
            default:  pending_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pending <= 1'b0;
        end else begin
            pending <= pending_nxt;
        end
    end
`else
    assign tick = move_map;
`endif

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        new_game    = 1'b0;
        do_shift    = 1'b0;
        enter_crash = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) begin
                    state_nxt = ST_RUN;
                    new_game  = 1'b1;
                end
            end
            ST_RUN: begin
                // A hit outranks a tick arriving in the same cycle.
                if (!run) begin
                    state_nxt = ST_IDLE;
                end else if (hit) begin
                    state_nxt   = ST_CRASH;
                    enter_crash = 1'b1;
                end else if (tick) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The shift always completes, even if run drops this cycle.
                do_shift  = 1'b1;
                state_nxt = run ? ST_RUN : ST_IDLE;
            end
            ST_CRASH: begin
                if (!run) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Map, score and blank-row toggle
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            map_rows  <= '0;
            score     <= '0;
            zero_turn <= 1'b0;
            collision <= 1'b0;
        end else begin
            collision <= enter_crash;
            if (new_game) begin
                map_rows  <= '0;
                score     <= '0;
                zero_turn <= 1'b0;
            end else if (do_shift) begin
                map_rows  <= {map_rows[(ROWS-1)*LANES-1:0], ins_row};
                zero_turn <= ~zero_turn;
                if ((|bottom_row) && (score != '1)) begin
                    score <= score + SCORE_W'(1);
                end
            end
        end
    end

    assign crashed = (state == ST_CRASH);
    assign busy    = (state == ST_SHIFT);

endmodule
